// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one asynchronous-read IMEM port between CPU fetch and program loader
// Ports:
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   F_req_* / F_rsp_*             fetch request (read-only) and response valid/ready channels
//   L_req_* / L_rsp_*             loader request (read/write) and response valid/ready channels
//   Mem_addr/Mem_we/Mem_wdata     word index, write strobe and write data to the array
//   Mem_rdata                     asynchronous read data from the array
// Optional feature: define IMEM_ARB_ALIGN_CHK_EN to flag misaligned/out-of-range fetches
// (F_rsp_err = 1, NOP data) and suppress writes for misaligned/out-of-range loader writes.
module imem_arbiter #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  F_req_valid,
  output logic                  F_req_ready,
  input  logic [31:0]           F_req_addr,
  output logic                  F_rsp_valid,
  input  logic                  F_rsp_ready,
  output logic [31:0]           F_rsp_rdata,
  output logic                  F_rsp_err,
  input  logic                  L_req_valid,
  output logic                  L_req_ready,
  input  logic                  L_req_we,
  input  logic [31:0]           L_req_addr,
  input  logic [31:0]           L_req_wdata,
  output logic                  L_rsp_valid,
  input  logic                  L_rsp_ready,
  output logic [31:0]           L_rsp_rdata,
  output logic [DEPTH_LOG2-1:0] Mem_addr,
  output logic                  Mem_we,
  output logic [31:0]           Mem_wdata,
  input  logic [31:0]           Mem_rdata
);
  typedef enum logic [1:0] {IDLE, RESP_F, RESP_L} state_t;
  localparam logic FETCH = 1'b0, LOADER = 1'b1;
  state_t state;
  logic last_grant, grant_f, grant_l, f_bad, l_bad;
`ifdef IMEM_ARB_ALIGN_CHK_EN
  assign f_bad = (F_req_addr[1:0] != 2'b0) || (|(F_req_addr >> (DEPTH_LOG2 + 2)));
  assign l_bad = (L_req_addr[1:0] != 2'b0) || (|(L_req_addr >> (DEPTH_LOG2 + 2)));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{F_req_addr[31:DEPTH_LOG2+2], F_req_addr[1:0],
                              L_req_addr[31:DEPTH_LOG2+2], L_req_addr[1:0]};
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif
  // Grants are masked while reset is held so no write strobe or handshake leaks out of reset.
  // On contention the requester that was not granted last wins.
  assign grant_f = reset_n && state == IDLE && F_req_valid && (!L_req_valid || last_grant == LOADER);
  assign grant_l = reset_n && state == IDLE && L_req_valid && (!F_req_valid || last_grant == FETCH);
  assign F_req_ready = grant_f;
  assign L_req_ready = grant_l;
  assign Mem_addr = grant_l ? L_req_addr[DEPTH_LOG2+1:2] : F_req_addr[DEPTH_LOG2+1:2];
  assign Mem_we = grant_l && L_req_we && !l_bad;
  assign Mem_wdata = L_req_wdata;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_grant <= LOADER;
      F_rsp_valid <= 1'b0;
      F_rsp_rdata <= 32'h0;
      F_rsp_err <= 1'b0;
      L_rsp_valid <= 1'b0;
      L_rsp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_f) begin
            F_rsp_valid <= 1'b1;
            F_rsp_rdata <= f_bad ? 32'h0000_0013 : Mem_rdata;
            F_rsp_err <= f_bad;
            last_grant <= FETCH;
            state <= RESP_F;
          end else if (grant_l) begin
            L_rsp_valid <= 1'b1;
            L_rsp_rdata <= L_req_we ? 32'h0 : Mem_rdata;
            last_grant <= LOADER;
            state <= RESP_L;
          end
        end
        RESP_F: if (F_rsp_ready) begin
          F_rsp_valid <= 1'b0;
          state <= IDLE;
        end
        RESP_L: if (L_rsp_ready) begin
          L_rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed self-checking bench for imem_arbiter with a 16-word array model
module tb_imem_arbiter;
  logic clk = 1'b0, reset_n;
  logic F_req_valid, F_req_ready, F_rsp_valid, F_rsp_ready, F_rsp_err;
  logic [31:0] F_req_addr, F_rsp_rdata;
  logic L_req_valid, L_req_ready, L_req_we, L_rsp_valid, L_rsp_ready;
  logic [31:0] L_req_addr, L_req_wdata, L_rsp_rdata;
  logic [3:0] Mem_addr;
  logic Mem_we;
  logic [31:0] Mem_wdata, Mem_rdata;
  logic [31:0] mem [16];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  imem_arbiter #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .F_req_valid(F_req_valid), .F_req_ready(F_req_ready), .F_req_addr(F_req_addr),
    .F_rsp_valid(F_rsp_valid), .F_rsp_ready(F_rsp_ready), .F_rsp_rdata(F_rsp_rdata),
    .F_rsp_err(F_rsp_err),
    .L_req_valid(L_req_valid), .L_req_ready(L_req_ready), .L_req_we(L_req_we),
    .L_req_addr(L_req_addr), .L_req_wdata(L_req_wdata),
    .L_rsp_valid(L_rsp_valid), .L_rsp_ready(L_rsp_ready), .L_rsp_rdata(L_rsp_rdata),
    .Mem_addr(Mem_addr), .Mem_we(Mem_we), .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata)
  );
  assign Mem_rdata = mem[Mem_addr];
  always_ff @(posedge clk) if (Mem_we) mem[Mem_addr] <= Mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'hA0A0_A0A0;
    mem[2] = 32'h0094_47B3;
    reset_n = 1'b0;
    F_req_valid = 1'b0; F_req_addr = 32'h0; F_rsp_ready = 1'b1;
    L_req_valid = 1'b1; L_req_we = 1'b1; L_req_addr = 32'h4; L_req_wdata = 32'hDEAD_BEEF;
    L_rsp_ready = 1'b1;
    #1;
    chk("rst_f_valid", {31'b0, F_rsp_valid}, 32'd0);
    chk("rst_l_valid", {31'b0, L_rsp_valid}, 32'd0);
    chk("rst_f_rdata", F_rsp_rdata, 32'h0);
    chk("rst_l_rdata", L_rsp_rdata, 32'h0);
    chk("rst_f_err", {31'b0, F_rsp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, Mem_we}, 32'd0);
    chk("rst_l_ready", {31'b0, L_req_ready}, 32'd0);
    tick();
    L_req_valid = 1'b0;
    reset_n = 1'b1;
    // single fetch of word 2
    F_req_valid = 1'b1; F_req_addr = 32'h8;
    #1;
    chk("f1_req_ready", {31'b0, F_req_ready}, 32'd1);
    chk("f1_l_ready", {31'b0, L_req_ready}, 32'd0);
    chk("f1_mem_addr", {28'b0, Mem_addr}, 32'd2);
    chk("f1_mem_we", {31'b0, Mem_we}, 32'd0);
    tick();
    F_req_valid = 1'b0;
    chk("f1_rsp_valid", {31'b0, F_rsp_valid}, 32'd1);
    chk("f1_rsp_rdata", F_rsp_rdata, 32'h0094_47B3);
    chk("f1_rsp_err", {31'b0, F_rsp_err}, 32'd0);
    tick();
    chk("f1_rsp_clear", {31'b0, F_rsp_valid}, 32'd0);
    // loader write to word 3, then fetch it back
    L_req_valid = 1'b1; L_req_we = 1'b1; L_req_addr = 32'hC; L_req_wdata = 32'h00C5_A533;
    #1;
    chk("lw_req_ready", {31'b0, L_req_ready}, 32'd1);
    chk("lw_mem_we", {31'b0, Mem_we}, 32'd1);
    chk("lw_mem_addr", {28'b0, Mem_addr}, 32'd3);
    tick();
    L_req_valid = 1'b0;
    chk("lw_rsp_valid", {31'b0, L_rsp_valid}, 32'd1);
    chk("lw_rsp_rdata", L_rsp_rdata, 32'h0);
    chk("lw_mem_we_off", {31'b0, Mem_we}, 32'd0);
    tick();
    F_req_valid = 1'b1; F_req_addr = 32'hC;
    #1;
    chk("fw_req_ready", {31'b0, F_req_ready}, 32'd1);
    tick();
    F_req_valid = 1'b0;
    chk("fw_rsp_rdata", F_rsp_rdata, 32'h00C5_A533);
    tick();
    // fresh reset, then both requesters continuously valid: F,L,F,L
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    F_req_valid = 1'b1; F_req_addr = 32'hC;
    L_req_valid = 1'b1; L_req_we = 1'b0; L_req_addr = 32'h8;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d_f_ready", i), {31'b0, F_req_ready}, {31'b0, i % 2 == 0});
      chk($sformatf("rr%0d_l_ready", i), {31'b0, L_req_ready}, {31'b0, i % 2 == 1});
      tick();
      if (i % 2 == 0) chk($sformatf("rr%0d_f_rdata", i), F_rsp_rdata, 32'h00C5_A533);
      else chk($sformatf("rr%0d_l_rdata", i), L_rsp_rdata, 32'h0094_47B3);
      chk($sformatf("rr%0d_busy", i), {30'b0, F_req_ready, L_req_ready}, 32'd0);
      tick();
    end
    // fetch response backpressured for 5 cycles while loader waits
    F_rsp_ready = 1'b0;
    chk("bp_f_grant", {31'b0, F_req_ready}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_f_valid", i), {31'b0, F_rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_f_rdata", i), F_rsp_rdata, 32'h00C5_A533);
      chk($sformatf("bp%0d_l_ready", i), {31'b0, L_req_ready}, 32'd0);
      tick();
    end
    F_rsp_ready = 1'b1;
    #1;
    chk("bp_hs_l_ready", {31'b0, L_req_ready}, 32'd0);
    tick();
    chk("bp_after_l_ready", {31'b0, L_req_ready}, 32'd1);
    chk("bp_after_f_ready", {31'b0, F_req_ready}, 32'd0);
    // reset while in RESP_L
    tick();
    L_rsp_ready = 1'b0;
    chk("rl_l_valid", {31'b0, L_rsp_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rl_l_cleared", {31'b0, L_rsp_valid}, 32'd0);
    chk("rl_f_cleared", {31'b0, F_rsp_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    L_rsp_ready = 1'b1;
    #1;
    chk("rl_f_first", {31'b0, F_req_ready}, 32'd1);
    chk("rl_l_wait", {31'b0, L_req_ready}, 32'd0);
    tick();
    F_req_valid = 1'b0; L_req_valid = 1'b0;
    chk("rl_f_rsp", {31'b0, F_rsp_valid}, 32'd1);
    tick();
    // out-of-range fetch 0x40
    F_req_valid = 1'b1; F_req_addr = 32'h40;
    tick();
    F_req_valid = 1'b0;
`ifdef IMEM_ARB_ALIGN_CHK_EN
    chk("oor_err", {31'b0, F_rsp_err}, 32'd1);
    chk("oor_rdata", F_rsp_rdata, 32'h0000_0013);
    tick();
    F_req_valid = 1'b1; F_req_addr = 32'h6;
    tick();
    F_req_valid = 1'b0;
    chk("mis_err", {31'b0, F_rsp_err}, 32'd1);
    chk("mis_rdata", F_rsp_rdata, 32'h0000_0013);
    tick();
    L_req_valid = 1'b1; L_req_we = 1'b1; L_req_addr = 32'h41;
    #1;
    chk("mis_l_ready", {31'b0, L_req_ready}, 32'd1);
    chk("mis_l_we", {31'b0, Mem_we}, 32'd0);
    tick();
    L_req_valid = 1'b0;
    chk("mis_l_rsp", {31'b0, L_rsp_valid}, 32'd1);
`else
    chk("wrap_err", {31'b0, F_rsp_err}, 32'd0);
    chk("wrap_rdata", F_rsp_rdata, 32'hA0A0_A0A0);
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the CPU instruction fetch (read-only) and the program loader (read/write).
- The memory array is word-addressed with an asynchronous read; the arbiter drives its address, write enable and write data.
- Each requester uses a valid/ready request channel and a valid/ready response channel. At most one transaction is outstanding in total.
- Placed between the PC/fetch stage, the loader and the IMEM array.

Parameters:
- DEPTH_LOG2, 4, log2 of the memory depth in 32-bit words (default 16 words).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- F_req_valid  input  1  fetch request valid
- F_req_ready  output  1  fetch request accepted this cycle
- F_req_addr  input  32  fetch byte address
- F_rsp_valid  output  1  fetch response valid
- F_rsp_ready  input  1  fetch consumer ready
- F_rsp_rdata  output  32  fetched instruction
- F_rsp_err  output  1  fetch error (see Optional Feature)
- L_req_valid  input  1  loader request valid
- L_req_ready  output  1  loader request accepted this cycle
- L_req_we  input  1  1 = write, 0 = read
- L_req_addr  input  32  loader byte address
- L_req_wdata  input  32  loader write data
- L_rsp_valid  output  1  loader response valid
- L_rsp_ready  input  1  loader consumer ready
- L_rsp_rdata  output  32  read data; 0 for writes
- Mem_addr  output  DEPTH_LOG2  word index to the array
- Mem_we  output  1  array write strobe
- Mem_wdata  output  32  array write data
- Mem_rdata  input  32  array asynchronous read data

Behaviour:
- FSM states: IDLE, RESP_F, RESP_L. Reset state is IDLE.
- Reset values: all rsp_valid = 0, rsp_rdata = 0, F_rsp_err = 0, last_grant = LOADER, Mem_we = 0.
- Requests are accepted only in IDLE. Nothing is ever granted in RESP_F or RESP_L.
- IDLE, grant choice:
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant (round-robin).
- IDLE, grant cycle:
  - The granted req_ready is high combinationally. The other requester's req_ready is low.
  - Mem_addr = granted addr[DEPTH_LOG2+1:2]. addr[1:0] and bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the depth.
  - Mem_we = L_req_valid & L_req_we, only when the loader is granted.
- Clock edge after a grant:
  - A loader write commits at this edge.
  - Mem_rdata is captured into the granted requester's rsp_rdata (L_rsp_rdata = 0 for writes).
  - last_grant is updated.
  - FSM moves to RESP_F or RESP_L.
- Latency: request accept to rsp_valid is 1 cycle. Maximum throughput is 1 transaction per 2 cycles.
- RESP_x:
  - rsp_valid and rsp_rdata are held stable until rsp_ready is high.
  - On the edge where rsp_valid & rsp_ready: rsp_valid clears and the FSM returns to IDLE.
  - A waiting requester stalls (req_ready = 0) indefinitely if the response is backpressured.
- Mem_we is 0 in every state except an IDLE cycle with a granted loader write.
- A req_valid dropped before acceptance is simply ignored. No request is ever latched without req_ready.
- Reset asserted mid-transaction: the FSM returns to IDLE at once and any pending response is discarded. A write commits only if its grant edge occurred before reset asserted.

Optional Feature:
- Macro: IMEM_ARB_ALIGN_CHK_EN.
- With the macro defined:
  - A fetch with F_req_addr[1:0] != 0, or with any address bit above DEPTH_LOG2+1 set, is still accepted and completes normally through RESP_F.
  - Its response has F_rsp_err = 1 and F_rsp_rdata = 32'h00000013 (NOP).
  - Loader writes with the same violations are acknowledged, but Mem_we stays 0.
- Without the macro: F_rsp_err is tied to 0 and addresses truncate/wrap as described above.

Test Plan:
- Reset, then fetch only: F_req_addr = 0x8 with array word 2 = 0x009447B3 -> F_req_ready = 1 in cycle 0, F_rsp_valid = 1 with rdata 0x009447B3 in cycle 1.
- Loader write addr 0x0C, data 0x00C5A533, then fetch 0x0C -> Mem_we pulses one cycle; fetch returns 0x00C5A533.
- Both requesters valid continuously, both rsp_ready = 1 -> grants alternate F, L, F, L, with fetch first after reset; one response every 2 cycles.
- Hold F_rsp_ready = 0 for 5 cycles with L_req_valid high -> F_rsp_valid and data stable for 5 cycles, L_req_ready = 0; loader is granted the cycle after the handshake.
- Assert reset_n = 0 while in RESP_L -> all rsp_valid = 0 immediately; after release, FSM is in IDLE and fetch wins the first contested grant.
- With IMEM_ARB_ALIGN_CHK_EN, fetch 0x6 -> F_rsp_err = 1, rdata 0x00000013; fetch 0x40 (DEPTH_LOG2 = 4) -> err = 1. Without the macro, 0x40 reads word 0 and err = 0.
